// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - round-robin arbiter sharing the LC-3 single-port memory between CPU and DMA
module lc3_mem_arbiter #(
   parameter int MEM_LAT = 2,
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ready,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int CW = 4;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_dma;
   logic          gnt_dma;
   logic          pick_dma;

   // DMA wins only when it is alone, or on a tie when the CPU was served last.
   assign pick_dma = dma_req && (!cpu_req || !last_dma);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         last_dma  <= 1'b1;
         gnt_dma   <= 1'b0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
         cpu_ready <= 1'b0;
         dma_ready <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         dma_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || dma_req) begin
                  gnt_dma   <= pick_dma;
                  mem_we    <= pick_dma ? dma_we    : cpu_we;
                  mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
                  mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
                  mem_en    <= 1'b1;
                  busy      <= 1'b1;
                  cnt       <= CNT_INIT;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  // mem_we still holds the latched direction of this access
                  if (!mem_we) begin
                     if (gnt_dma) dma_rdata <= mem_rdata;
                     else         cpu_rdata <= mem_rdata;
                  end
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  cpu_ready <= !gnt_dma;
                  dma_ready <= gnt_dma;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               last_dma <= gnt_dma;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
